// File: rtl/vga_fb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter_pkg
//   Shared types and constants for the framebuffer arbiter and the VGA
//   timing block.
//
//   pixel_t       : 24-bit RGB pixel, 8 bits per channel (red in the MSBs).
//   grant_e       : SRAM port owner for the next cycle.
//   BLACK_PIXEL   : value returned for out-of-range fetches.
//   DEF_H_PIXELS  : default visible pixels per line (shared with vga timing).
//   DEF_V_LINES   : default visible lines per frame (shared with vga timing).
// ---------------------------------------------------------------------------
package vga_fb_arbiter_pkg;

    localparam int unsigned DEF_H_PIXELS = 640;
    localparam int unsigned DEF_V_LINES  = 480;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_t;

    typedef enum logic [1:0] {
        G_IDLE  = 2'd0,
        G_READ  = 2'd1,
        G_WRITE = 2'd2
    } grant_e;

    localparam pixel_t BLACK_PIXEL = '0;

endpackage

// File: rtl/vga_fb_arbiter_addr_calc.sv
// ---------------------------------------------------------------------------
// fb_addr_calc
//   Combinational (x, y) to linear framebuffer word address, plus an
//   out-of-range flag. Instantiated once for the read side and once for the
//   write side of the arbiter.
//
//   x, y  : in  10-bit column / row.
//   addr  : out y*H_PIXELS + x in ADDR_W bits (only meaningful when !oob).
//   oob   : out high when x >= H_PIXELS or y >= V_LINES.
// ---------------------------------------------------------------------------
module fb_addr_calc
    import vga_fb_arbiter_pkg::*;
#(
    parameter int unsigned H_PIXELS = DEF_H_PIXELS,
    parameter int unsigned V_LINES  = DEF_V_LINES,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    always_comb begin
        addr = ADDR_W'(y) * ADDR_W'(H_PIXELS) + ADDR_W'(x);
        oob  = (32'(x) >= H_PIXELS) || (32'(y) >= V_LINES);
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//   Shares one single-port synchronous framebuffer SRAM between the VGA
//   pixel fetch (fixed priority, one request per cycle) and a draw/CPU
//   writer using a valid/ready handshake. Read data returns to the VGA side
//   at a fixed latency of 2+RD_LATENCY cycles after the request.
//
//   Optional build macro: FB_DOUBLE_BUFFER_EN
//     Adds a second framebuffer selected by an extra mem_addr MSB. Reads
//     use the front bank, writes the back bank; the banks swap on the first
//     frame_start after a swap_req.
//
//   Ports
//     clock        in   sole clock, rising edge
//     reset        in   synchronous, active-low
//     vga_req      in   pixel fetch request
//     vga_x/vga_y  in   fetch coordinates
//     vga_valid    out  vga_data valid this cycle
//     vga_data     out  fetched pixel (black when out of range)
//     wr_valid     in   write request
//     wr_ready     out  write accepted when high with wr_valid
//     wr_x/wr_y    in   write coordinates
//     wr_data      in   pixel to write
//     frame_start  in   start-of-vblank pulse (used only with the macro)
//     swap_req     in   request a bank swap (macro only)
//     swap_pending out  swap waiting for frame_start (macro only)
//     mem_en       out  SRAM enable
//     mem_we       out  SRAM write enable
//     mem_addr     out  SRAM word address (+1 bank MSB with the macro)
//     mem_wdata    out  SRAM write data
//     mem_rdata    in   SRAM read data
// ---------------------------------------------------------------------------
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int unsigned H_PIXELS   = DEF_H_PIXELS,
    parameter int unsigned V_LINES    = DEF_V_LINES,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    output logic              vga_valid,
    output logic [23:0]       vga_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [23:0]       wr_data,
    input  logic              frame_start,
`ifdef FB_DOUBLE_BUFFER_EN
    input  logic              swap_req,
    output logic              swap_pending,
    output logic [ADDR_W:0]   mem_addr,
`else
    output logic [ADDR_W-1:0] mem_addr,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata
);

`ifdef FB_DOUBLE_BUFFER_EN
    localparam int unsigned MEM_AW = ADDR_W + 1;
`else
    localparam int unsigned MEM_AW = ADDR_W;
`endif

    // Elaboration-time parameter legality checks.
    if ((64'd1 << ADDR_W) < 64'(H_PIXELS) * 64'(V_LINES)) begin : g_bad_addr_w
        $error("ADDR_W too small to address H_PIXELS*V_LINES words");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_rd_latency
        $error("RD_LATENCY must be in 1..3");
    end

    // -----------------------------------------------------------------------
    // Address generation
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_oob;
    logic              wr_oob;
    logic [MEM_AW-1:0] rd_full;
    logic [MEM_AW-1:0] wr_full;

    fb_addr_calc #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES),
        .ADDR_W   (ADDR_W)
    ) u_rd_addr (
        .x    (vga_x),
        .y    (vga_y),
        .addr (rd_addr),
        .oob  (rd_oob)
    );

    fb_addr_calc #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES),
        .ADDR_W   (ADDR_W)
    ) u_wr_addr (
        .x    (wr_x),
        .y    (wr_y),
        .addr (wr_addr),
        .oob  (wr_oob)
    );

`ifdef FB_DOUBLE_BUFFER_EN
    logic front;

    // A request arriving on the swap edge stays pending for the next frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            front        <= 1'b0;
            swap_pending <= 1'b0;
        end else if (frame_start && swap_pending) begin
            front        <= ~front;
            swap_pending <= swap_req;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    always_comb begin
        rd_full = {front, rd_addr};
        wr_full = {~front, wr_addr};
    end
`else
    logic unused_frame_start;

    always_comb begin
        unused_frame_start = frame_start;
        rd_full            = rd_addr;
        wr_full            = wr_addr;
    end
`endif

    // -----------------------------------------------------------------------
    // Arbitration: VGA has absolute priority; the writer is ready whenever
    // the VGA side is not requesting (including for out-of-range writes).
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ready = reset && !vga_req;
    end

    // -----------------------------------------------------------------------
    // Grant FSM
    // -----------------------------------------------------------------------
    grant_e            state;
    grant_e            next_state;
    logic [MEM_AW-1:0] addr_q;
    logic [23:0]       wdata_q;
    logic              oob_q;

    always_ff @(posedge clock) begin : state_reg
        if (!reset) begin
            state <= G_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin : next_state_logic
        next_state = G_IDLE;
        if (vga_req) begin
            next_state = G_READ;
        end else if (wr_valid) begin
            next_state = G_WRITE;
        end
    end

    // Access parameters captured alongside the grant; held while idle.
    always_ff @(posedge clock) begin : access_reg
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            oob_q   <= 1'b0;
        end else begin
            case (next_state)
                G_READ: begin
                    addr_q <= rd_full;
                    oob_q  <= rd_oob;
                end
                G_WRITE: begin
                    addr_q  <= wr_full;
                    wdata_q <= wr_data;
                    oob_q   <= wr_oob;
                end
                default: begin
                end
            endcase
        end
    end

    // Out-of-range accesses keep their grant slot but never touch the SRAM.
    always_comb begin : output_logic
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        case (state)
            G_READ: begin
                mem_en = !oob_q;
            end
            G_WRITE: begin
                mem_en = !oob_q;
                mem_we = !oob_q;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Read return pipeline: stage i of the tag shift register lines up with
    // cycle N+1+i, so the last stage coincides with valid mem_rdata.
    // -----------------------------------------------------------------------
    logic [RD_LATENCY:0] tag_valid;
    logic [RD_LATENCY:0] tag_oob;
    pixel_t              rd_pixel;

    always_comb begin
        rd_pixel = tag_oob[RD_LATENCY] ? BLACK_PIXEL : pixel_t'(mem_rdata);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tag_valid <= '0;
            tag_oob   <= '0;
            vga_valid <= 1'b0;
            vga_data  <= '0;
        end else begin
            tag_valid <= {tag_valid[RD_LATENCY-1:0], vga_req};
            tag_oob   <= {tag_oob[RD_LATENCY-1:0], rd_oob};
            vga_valid <= tag_valid[RD_LATENCY];
            if (tag_valid[RD_LATENCY]) begin
                vga_data <= rd_pixel;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    localparam int HP = 640;
    localparam int VL = 480;
    localparam int AW = 19;
    localparam int RL = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [9:0]  vga_x;
    logic [9:0]  vga_y;
    logic        vga_valid;
    logic [23:0] vga_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [9:0]  wr_y;
    logic [23:0] wr_data;
    logic        frame_start;
    logic        mem_en;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    always #5 clock = ~clock;

    vga_fb_arbiter #(
        .H_PIXELS   (HP),
        .V_LINES    (VL),
        .ADDR_W     (AW),
        .RD_LATENCY (RL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vga_req     (vga_req),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_valid   (vga_valid),
        .vga_data    (vga_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Power-up content of every framebuffer word, distinct per address.
    function automatic logic [23:0] init_word(input int a);
        return 24'((a * 40503) ^ 32'h00C0FFEE);
    endfunction

    // SRAM with one-cycle read latency; garbage on the bus when not reading.
    logic [23:0] sram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = init_word(i);
    end
    always @(posedge clock) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
        else mem_rdata <= 24'($urandom);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [23:0] data;
    } resp_t;

    logic [23:0] fb_model [int];
    resp_t       rq[$];
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int          t = 0;
    bit          armed = 0;
    logic        exp_en, exp_we, exp_zero;
    logic [AW-1:0] exp_addr;
    logic [23:0] exp_wdata;

    function automatic logic [23:0] model_read(input int a);
        if (fb_model.exists(a)) return fb_model[a];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h want 0x%0h", name, t, act, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs, apply inputs, advance model.
    task automatic step(input logic rst, input logic vr, input int vx, input int vy,
                        input logic wv, input int wx, input int wy, input logic [23:0] wd);
        logic exp_v;
        logic oob;
        int   a;
        if (armed) begin
            exp_v = (rq.size() > 0) && (rq[0].due == t);
            chk("vga_valid", vga_valid, exp_v);
            if (exp_v) begin
                chk("vga_data", vga_data, rq[0].data);
                void'(rq.pop_front());
            end else if (exp_zero) begin
                chk("vga_data_rst", vga_data, 0);
            end
            chk("mem_en", mem_en, exp_en);
            chk("mem_we", mem_we, exp_we);
            if (exp_en || exp_zero) chk("mem_addr", mem_addr, exp_addr);
            if (exp_we || exp_zero) chk("mem_wdata", mem_wdata, exp_wdata);
        end
        reset = rst; vga_req = vr; vga_x = 10'(vx); vga_y = 10'(vy);
        wr_valid = wv; wr_x = 10'(wx); wr_y = 10'(wy); wr_data = wd;
        #1;
        chk("wr_ready", wr_ready, rst && !vr);
        if (!rst) begin
            rq.delete();
            exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_zero = 1;
            armed = 1;
        end else begin
            exp_zero = 0;
            if (vr) begin
                oob = (vx >= HP) || (vy >= VL);
                a = vy * HP + vx;
                exp_en = !oob; exp_we = 0;
                if (!oob) exp_addr = AW'(a);
                rq.push_back('{t + 2 + RL, oob ? 24'h0 : model_read(a)});
            end else if (wv) begin
                oob = (wx >= HP) || (wy >= VL);
                a = wy * HP + wx;
                exp_en = !oob; exp_we = !oob;
                if (!oob) begin
                    exp_addr = AW'(a);
                    exp_wdata = wd;
                    fb_model[a] = wd;
                end
            end else begin
                exp_en = 0; exp_we = 0;
            end
        end
        @(posedge clock);
        t++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 24'h0);
    endtask

    function automatic int rc(input int lim);
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(lim - 4, lim + 3));
        return int'($urandom_range(0, 7));
    endfunction

    logic        r_rst, r_vr, r_wv, hold;
    int          r_vx, r_vy, r_wx, r_wy;
    logic [23:0] r_wd;

    initial begin
        reset = 0; vga_req = 0; vga_x = '0; vga_y = '0;
        wr_valid = 0; wr_x = '0; wr_y = '0; wr_data = '0; frame_start = 0;
        @(negedge clock);
        step(0, 0, 0, 0, 0, 0, 0, 24'h0);
        step(0, 0, 0, 0, 0, 0, 0, 24'h0);
        chk("pin_reset_valid", vga_valid, 0);
        chk("pin_reset_en", mem_en, 0);

        // Write then read back (3,2) -> word 1283.
        step(1, 0, 0, 0, 1, 3, 2, 24'h123456);
        chk("pin_wr_addr_1283", mem_addr, 1283);
        idle(1);
        step(1, 1, 3, 2, 0, 0, 0, 24'h0);
        chk("pin_rd_addr_1283", mem_addr, 1283);
        chk("pin_rd_en", mem_en, 1);
        chk("pin_rd_we", mem_we, 0);
        idle(2);
        chk("pin_rd_valid", vga_valid, 1);
        chk("pin_rd_data", vga_data, 24'h123456);
        idle(1);

        // Last pixel write.
        step(1, 0, 0, 0, 1, 639, 479, 24'hFF0000);
        chk("pin_last_addr", mem_addr, 307199);
        chk("pin_last_we", mem_we, 1);
        chk("pin_last_wdata", mem_wdata, 24'hFF0000);
        idle(1);

        // Contention: 4 reads win over a held write.
        for (int k = 0; k < 4; k++) step(1, 1, 4 + k, 1, 1, 10, 10, 24'hABCDEF);
        step(1, 0, 0, 0, 1, 10, 10, 24'hABCDEF);
        chk("pin_cont_we", mem_we, 1);
        chk("pin_cont_addr", mem_addr, 6410);
        idle(4);

        // Out-of-range read and write.
        step(1, 1, 640, 0, 0, 0, 0, 24'h0);
        chk("pin_oob_rd_en", mem_en, 0);
        idle(2);
        chk("pin_oob_rd_valid", vga_valid, 1);
        chk("pin_oob_rd_data", vga_data, 0);
        idle(1);
        step(1, 0, 0, 0, 1, 0, 480, 24'h777777);
        chk("pin_oob_wr_en", mem_en, 0);
        idle(1);

        // Reset in the middle of a read burst.
        step(1, 1, 1, 1, 0, 0, 0, 24'h0);
        step(1, 1, 2, 1, 0, 0, 0, 24'h0);
        step(0, 1, 3, 1, 0, 0, 0, 24'h0);
        chk("pin_midrst_valid", vga_valid, 0);
        chk("pin_midrst_en", mem_en, 0);
        idle(4);

        // Randomized traffic; the writer holds its request until accepted.
        hold = 0;
        r_wv = 0; r_wx = 0; r_wy = 0; r_wd = '0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 199) != 0);
            r_vr  = ($urandom_range(0, 9) < 4);
            r_vx  = rc(HP);
            r_vy  = rc(VL);
            if (!hold) begin
                r_wv = 1'($urandom_range(0, 1));
                r_wx = rc(HP);
                r_wy = rc(VL);
                r_wd = 24'($urandom);
            end
            frame_start = 1'($urandom_range(0, 1));
            step(r_rst, r_vr, r_vx, r_vy, r_wv, r_wx, r_wy, r_wd);
            hold = r_wv && !(r_rst && !r_vr);
        end
        frame_start = 0;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
